// File: rtl/rv32_bp_pkg.sv
// Shared branch-predictor definitions: history/counter widths, the
// counter reset value, the matching typedefs and the saturating update.
package rv32_bp_pkg;

   localparam int GHR_W     = 4;
   localparam int CTR_W     = 2;
   localparam int CTR_INIT  = 1;
   localparam int PHT_DEPTH = 1 << GHR_W;

   typedef logic [GHR_W-1:0] ghr_t;
   typedef logic [CTR_W-1:0] ctr_t;

   localparam ctr_t CTR_MAX = {CTR_W{1'b1}};
   localparam ctr_t CTR_MIN = {CTR_W{1'b0}};
   localparam ctr_t CTR_RST = ctr_t'(CTR_INIT);

   // Move a counter one step toward the outcome, holding at either rail.
   function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
      ctr_t result;
      if (taken) begin
         if (ctr == CTR_MAX) result = ctr;
         else                result = ctr + ctr_t'(1);
      end else begin
         if (ctr == CTR_MIN) result = ctr;
         else                result = ctr - ctr_t'(1);
      end
      return result;
   endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch-side lookup and Execute-side resolve signals of the gshare predictor.
// master = pipeline side, slave = predictor side.
interface gshare_predictor_if import rv32_bp_pkg::*; ();

   logic [31:0] fetch_pc;
   logic        fetch_valid;
   logic        btb_hit;
   ghr_t        btb_index;
   logic        pred_taken;
   ghr_t        pred_ghr;
   logic        resolve_valid;
   logic [31:0] resolve_pc;
   ghr_t        resolve_ghr;
   logic        resolve_taken;
   logic        resolve_mispred;

   modport master (
      output fetch_pc, fetch_valid, btb_hit,
      output resolve_valid, resolve_pc, resolve_ghr, resolve_taken, resolve_mispred,
      input  btb_index, pred_taken, pred_ghr
   );

   modport slave (
      input  fetch_pc, fetch_valid, btb_hit,
      input  resolve_valid, resolve_pc, resolve_ghr, resolve_taken, resolve_mispred,
      output btb_index, pred_taken, pred_ghr
   );

endinterface

// File: rtl/bp_sat_counter_table.sv
// Pattern history table: 2**GHR_W saturating counters with one
// combinational read port, one saturating write port and async reset.
module bp_sat_counter_table import rv32_bp_pkg::*; (
   input  logic clk,
   input  logic rst,
   input  ghr_t rd_index,
   output ctr_t rd_ctr,
   input  logic wr_en,
   input  ghr_t wr_index,
   input  logic wr_taken
);

   ctr_t pht [PHT_DEPTH];

   // Read returns the stored value; a same-cycle write is seen next cycle.
   assign rd_ctr = pht[rd_index];

   // Counter storage: reset to weakly not-taken, train on each write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PHT_DEPTH; i++) begin
            pht[i] <= CTR_RST;
         end
      end else if (wr_en) begin
         pht[wr_index] <= sat_update(pht[wr_index], wr_taken);
      end
   end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor with speculative global history register.
// Optional write-through forwarding from the resolve port to the lookup
// port is enabled by defining GSHARE_BYPASS_EN.
module gshare_predictor import rv32_bp_pkg::*; (
   input  logic               clk,
   input  logic               rst,
   gshare_predictor_if.slave  bp
);

   ghr_t ghr;
   ghr_t ghr_next;
   ghr_t lookup_index;
   ghr_t resolve_index;
   ctr_t lookup_ctr;
   ctr_t eff_ctr;
   logic taken_bit;
   logic repair;

   assign lookup_index  = bp.fetch_pc[GHR_W-1:0] ^ ghr;
   assign resolve_index = bp.resolve_pc[GHR_W-1:0] ^ bp.resolve_ghr;
   assign repair        = bp.resolve_valid & bp.resolve_mispred;

   bp_sat_counter_table u_pht (
      .clk      (clk),
      .rst      (rst),
      .rd_index (lookup_index),
      .rd_ctr   (lookup_ctr),
      .wr_en    (bp.resolve_valid),
      .wr_index (resolve_index),
      .wr_taken (bp.resolve_taken)
   );

   // Select the counter value the prediction is taken from.
   always_comb begin
      eff_ctr = lookup_ctr;
`ifdef GSHARE_BYPASS_EN
      if (bp.resolve_valid && (resolve_index == lookup_index)) begin
         eff_ctr = sat_update(lookup_ctr, bp.resolve_taken);
      end else begin
         eff_ctr = lookup_ctr;
      end
`endif
      taken_bit = bp.btb_hit & eff_ctr[CTR_W-1];
   end

   // Next history: mispredict repair wins over the fetch-side shift.
   always_comb begin
      ghr_next = ghr;
      if (repair) begin
         ghr_next = {bp.resolve_ghr[GHR_W-2:0], bp.resolve_taken};
      end else if (bp.fetch_valid && bp.btb_hit) begin
         ghr_next = {ghr[GHR_W-2:0], taken_bit};
      end else begin
         ghr_next = ghr;
      end
   end

   // Global history register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ghr <= {GHR_W{1'b0}};
      else     ghr <= ghr_next;
   end

   assign bp.btb_index  = lookup_index;
   assign bp.pred_taken = taken_bit;
   assign bp.pred_ghr   = ghr;

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed vector table,
// an async reset pulse, forwarding corner case and randomized traffic
// checked against an array-based reference model.
module tb_gshare_predictor;
   import rv32_bp_pkg::*;

`ifdef GSHARE_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   gshare_predictor_if bp ();
   gshare_predictor dut (.clk(clk), .rst(rst), .bp(bp));

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] fpc;
      logic        fv, hit, rv;
      logic [31:0] rpc;
      logic [3:0]  rghr;
      logic        rt, rmis;
      logic [3:0]  e_idx;
      logic        e_taken;
      logic [3:0]  e_ghr;
   } vec_t;

   vec_t tbl[$];
   int   pht[16];
   int   mghr;

   function automatic vec_t mk(input logic [31:0] fpc, input logic fv, input logic hit,
                               input logic rv, input logic [31:0] rpc, input logic [3:0] rghr,
                               input logic rt, input logic rmis,
                               input logic [3:0] e_idx, input logic e_taken, input logic [3:0] e_ghr);
      vec_t v;
      v.fpc = fpc; v.fv = fv; v.hit = hit; v.rv = rv; v.rpc = rpc; v.rghr = rghr;
      v.rt = rt; v.rmis = rmis; v.e_idx = e_idx; v.e_taken = e_taken; v.e_ghr = e_ghr;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bp.fetch_pc = v.fpc; bp.fetch_valid = v.fv; bp.btb_hit = v.hit;
      bp.resolve_valid = v.rv; bp.resolve_pc = v.rpc; bp.resolve_ghr = v.rghr;
      bp.resolve_taken = v.rt; bp.resolve_mispred = v.rmis;
   endtask

   // Drive a vector just after an edge and check the lookup before the next edge.
   task automatic apply(input vec_t v, input string tag);
      @(posedge clk); #1;
      drive(v);
      #1;
      check({tag, ".btb_index"},  int'(bp.btb_index),  int'(v.e_idx));
      check({tag, ".pred_taken"}, int'(bp.pred_taken), int'(v.e_taken));
      check({tag, ".pred_ghr"},   int'(bp.pred_ghr),   int'(v.e_ghr));
   endtask

   task automatic do_reset();
      drive(mk(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0));
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      do_reset();

      // Reset state and first lookup
      tbl.push_back(mk(32'h8, 1, 1, 0, 32'h0, 4'h0, 0, 0, 4'h8, 0, 4'h0));
      // Two taken trainings of PHT[8]: 1->2->3
      tbl.push_back(mk(32'h8, 0, 0, 1, 32'h8, 4'h0, 1, 0, 4'h8, 0, 4'h0));
      tbl.push_back(mk(32'h8, 0, 0, 1, 32'h8, 4'h0, 1, 0, 4'h8, 0, 4'h0));
      tbl.push_back(mk(32'h8, 0, 1, 0, 32'h0, 4'h0, 0, 0, 4'h8, 1, 4'h0));
      // Three more taken: stays 3; then two not-taken reveal 3->2->1
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(32'h8, 0, 0, 1, 32'h8, 4'h0, 1, 0, 4'h8, 0, 4'h0));
      tbl.push_back(mk(32'h8, 0, 1, 0, 32'h0, 4'h0, 0, 0, 4'h8, 1, 4'h0));
      tbl.push_back(mk(32'h8, 0, 0, 1, 32'h8, 4'h0, 0, 0, 4'h8, 0, 4'h0));
      tbl.push_back(mk(32'h8, 0, 1, 0, 32'h0, 4'h0, 0, 0, 4'h8, 1, 4'h0));
      tbl.push_back(mk(32'h8, 0, 0, 1, 32'h8, 4'h0, 0, 0, 4'h8, 0, 4'h0));
      tbl.push_back(mk(32'h8, 0, 1, 0, 32'h0, 4'h0, 0, 0, 4'h8, 0, 4'h0));
      // Five not-taken at PHT[3] hold at 0, then two taken give 2
      tbl.push_back(mk(32'h3, 0, 0, 1, 32'h3, 4'h0, 0, 0, 4'h3, 0, 4'h0));
      tbl.push_back(mk(32'h3, 0, 0, 1, 32'h3, 4'h0, 0, 0, 4'h3, 0, 4'h0));
      tbl.push_back(mk(32'h3, 0, 1, 0, 32'h0, 4'h0, 0, 0, 4'h3, 0, 4'h0));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(32'h3, 0, 0, 1, 32'h3, 4'h0, 0, 0, 4'h3, 0, 4'h0));
      tbl.push_back(mk(32'h3, 0, 1, 0, 32'h0, 4'h0, 0, 0, 4'h3, 0, 4'h0));
      tbl.push_back(mk(32'h3, 0, 0, 1, 32'h3, 4'h0, 1, 0, 4'h3, 0, 4'h0));
      tbl.push_back(mk(32'h3, 0, 0, 1, 32'h3, 4'h0, 1, 0, 4'h3, 0, 4'h0));
      tbl.push_back(mk(32'h3, 0, 1, 0, 32'h0, 4'h0, 0, 0, 4'h3, 1, 4'h0));
      // Repair loads ghr=0101 (PHT[2] 1->2)
      tbl.push_back(mk(32'h0, 0, 0, 1, 32'h0, 4'h2, 1, 1, 4'h0, 0, 4'h0));
      // Fetch shift predicting taken vs same-cycle mispredict: repair wins -> 0110
      tbl.push_back(mk(32'h6, 1, 1, 1, 32'hC, 4'h3, 0, 1, 4'h3, 1, 4'h5));
      // fetch_valid=0 with btb_hit=1 freezes ghr
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(32'h6, 0, 1, 0, 32'h0, 4'h0, 0, 0, 4'h0, 0, 4'h6));
      tbl.push_back(mk(32'hA, 0, 1, 0, 32'h0, 4'h0, 0, 0, 4'hC, 0, 4'h6));
      // Speculative shift of a taken prediction: 0110 -> 1101
      tbl.push_back(mk(32'h4, 1, 1, 0, 32'h0, 4'h0, 0, 0, 4'h2, 1, 4'h6));
      tbl.push_back(mk(32'h0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 4'hD, 0, 4'hD));

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], $sformatf("vec%0d", i));
      end

      // Reset pulse between edges: state clears without a clock edge
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("rst_async.pred_ghr", int'(bp.pred_ghr), 0);
      bp.btb_hit = 1'b1;
      bp.fetch_valid = 1'b0;
      bp.resolve_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         bp.fetch_pc = 32'(i);
         #1;
         check($sformatf("rst_async.taken%0d", i), int'(bp.pred_taken), 0);
      end
      @(negedge clk);
      rst = 1'b0;

      // PHT[15] was 0 before reset; one taken update after reset must make it 2
      apply(mk(32'h0, 0, 0, 1, 32'hF, 4'h0, 1, 0, 4'h0, 0, 4'h0), "post_rst_a");
      apply(mk(32'hF, 0, 1, 0, 32'h0, 4'h0, 0, 0, 4'hF, 1, 4'h0), "post_rst_b");
      // Same-cycle read/write at index 4 (counter 1, taken)
      apply(mk(32'h4, 0, 1, 1, 32'h4, 4'h0, 1, 0, 4'h4, BYP, 4'h0), "rw_same_a");
      apply(mk(32'h4, 0, 1, 0, 32'h0, 4'h0, 0, 0, 4'h4, 1, 4'h0), "rw_same_b");
      // Speculative shift uses the forwarded bit when forwarding is built in
      apply(mk(32'h1, 1, 1, 1, 32'h1, 4'h0, 1, 0, 4'h1, BYP, 4'h0), "fwd_shift_a");
      apply(mk(32'h0, 0, 0, 0, 32'h0, 4'h0, 0, 0, {3'b000, BYP}, 0, {3'b000, BYP}), "fwd_shift_b");

      // Randomized traffic against the reference model
      do_reset();
      mghr = 0;
      for (int i = 0; i < 16; i++) pht[i] = CTR_INIT;
      for (int n = 0; n < 600; n++) begin
         vec_t v;
         int idx, ridx, c, pred, cmax;
         cmax = (1 << CTR_W) - 1;
         v.fpc  = $urandom;
         v.fv   = 1'($urandom_range(0, 3) != 0);
         v.hit  = 1'($urandom_range(0, 1));
         v.rv   = 1'($urandom_range(0, 1));
         v.rghr = 4'($urandom_range(0, 15));
         v.rt   = 1'($urandom_range(0, 1));
         v.rmis = 1'($urandom_range(0, 3) == 0);
         v.rpc  = $urandom;
         idx = (int'(v.fpc[3:0]) ^ mghr) & 15;
         if ($urandom_range(0, 3) == 0) v.rpc[3:0] = 4'(idx) ^ v.rghr;
         ridx = int'(v.rpc[3:0] ^ v.rghr);
         c = pht[idx];
         if (BYP && v.rv && ridx == idx) c = v.rt ? ((c < cmax) ? c + 1 : c) : ((c > 0) ? c - 1 : c);
         pred = (v.hit && c >= (1 << (CTR_W - 1))) ? 1 : 0;
         v.e_idx = 4'(idx); v.e_taken = 1'(pred); v.e_ghr = 4'(mghr);
         apply(v, $sformatf("rnd%0d", n));
         if (v.rv && v.rmis)      mghr = ((int'(v.rghr) << 1) | int'(v.rt)) & 15;
         else if (v.fv && v.hit)  mghr = ((mghr << 1) | pred) & 15;
         if (v.rv) begin
            if (v.rt) pht[ridx] = (pht[ridx] < cmax) ? pht[ridx] + 1 : pht[ridx];
            else      pht[ridx] = (pht[ridx] > 0) ? pht[ridx] - 1 : pht[ridx];
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
